// File: rtl/block_serializer_if.sv
`default_nettype none
// ============================================================================
// Module  : block_serializer_if
// Brief   : Wide-block input and word-stream output bundle of block_serializer.
// Revision: 1.0
// ============================================================================
interface block_serializer_if #(
    parameter int WORDS = 40,
    parameter int WIDTH = 64
);
    logic                   blk_valid;
    logic                   blk_ready;
    logic [WORDS*WIDTH-1:0] blk_data;
    logic                   word_valid;
    logic                   word_ready;
    logic [WIDTH-1:0]       word_data;
    logic [5:0]             word_idx;
    logic                   word_last;
    logic [15:0]            blk_count;

    // Serializer side: accepts blocks, produces words.
    modport slave (
        input  blk_valid,
        input  blk_data,
        input  word_ready,
        output blk_ready,
        output word_valid,
        output word_data,
        output word_idx,
        output word_last,
        output blk_count
    );

    // Environment side: offers blocks, consumes words.
    modport master (
        output blk_valid,
        output blk_data,
        output word_ready,
        input  blk_ready,
        input  word_valid,
        input  word_data,
        input  word_idx,
        input  word_last,
        input  blk_count
    );
endinterface
`default_nettype wire

// File: rtl/block_serializer.sv
`default_nettype none
// ============================================================================
// Module  : block_serializer
// Brief   : Captures a WORDS*WIDTH block and emits it word by word, highest
//           index first, with back-to-back block reload on the last word.
// Revision: 1.0
// ============================================================================
module block_serializer #(
    parameter int WORDS = 40,
    parameter int WIDTH = 64
) (
    input  logic               clock,
    input  logic               reset,
    block_serializer_if.slave  bus
);
    localparam int         c_IW       = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [5:0] c_LAST_IDX = 6'(WORDS - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [5:0]       r_idx;
    logic [5:0]       w_idx_nxt;
    logic [15:0]      r_count;
    logic [WIDTH-1:0] r_hold [WORDS];

    logic w_valid;
    logic w_word_hs;
    logic w_last_hs;
    logic w_blk_ready;
    logic w_blk_hs;

    always_comb begin
        w_valid     = (r_state == S_SEND);
        w_word_hs   = w_valid && bus.word_ready;
        w_last_hs   = w_word_hs && (r_idx == 6'd0);
        // Upstream may only load while idle or as the final word leaves.
        w_blk_ready = (r_state == S_IDLE) ? !reset : w_last_hs;
        w_blk_hs    = bus.blk_valid && w_blk_ready;
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            S_IDLE: begin
                if (w_blk_hs) begin
                    w_state_nxt = S_SEND;
                    w_idx_nxt   = c_LAST_IDX;
                end
            end
            S_SEND: begin
                if (w_blk_hs) begin
                    w_idx_nxt = c_LAST_IDX;
                end else if (w_last_hs) begin
                    w_state_nxt = S_IDLE;
                    w_idx_nxt   = 6'd0;
                end else if (w_word_hs) begin
                    w_idx_nxt = r_idx - 6'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = 6'd0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_idx   <= 6'd0;
            r_count <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            if (w_last_hs) begin
                r_count <= r_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < WORDS; k++) begin
                r_hold[k] <= '0;
            end
        end else if (w_blk_hs) begin
            for (int k = 0; k < WORDS; k++) begin
                r_hold[k] <= bus.blk_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Outputs come only from registers, so word_ready never reaches word_valid/data.
    assign bus.word_valid = w_valid;
    assign bus.word_data  = r_hold[r_idx[c_IW-1:0]];
    assign bus.word_idx   = r_idx;
    assign bus.word_last  = w_valid && (r_idx == 6'd0);
    assign bus.blk_count  = r_count;
    assign bus.blk_ready  = w_blk_ready;

endmodule
`default_nettype wire
